systolic_sequencer: RTL and testbench

Tile-level scheduler for the 4x4 systolic array. One `start` runs one output tile through a fixed sequence:
- clear the accumulators;
- stream `k_len` operand beats from the weight and input banked buffers into the MAC grid;
- flush the skew pipeline;
- commit all ARR_SIZE² accumulator results into the output buffer.

It sits between the instruction controller, which supplies `start`/`k_len`/`out_base`, and the datapath: banked buffers, MAC, Accumulator and Output_buffer.

---
 rtl/systolic_sequencer.sv | 167 ++++++++++++++++
 tb/tb_systolic_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// systolic_sequencer : runs one output tile (clear, compute, flush, store)
// Revision: 1.0
// ============================================================================
module systolic_sequencer #(
    parameter int ARR_SIZE  = 4,
    parameter int ADDR_W    = 7,
    parameter int OP_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           k_len,
    input  logic [OP_ADDR_W-1:0] out_base,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state_signal,
    output logic                 i_mode,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 acc_reset,
    output logic                 store_output,
    output logic [OP_ADDR_W-1:0] op_buf_addr
);

    localparam int STORE_LEN = ARR_SIZE * ARR_SIZE;
    localparam int CNT_W     = ($clog2(STORE_LEN + 1) > 8) ? $clog2(STORE_LEN + 1) : 8;

    localparam logic [CNT_W-1:0] c_FLUSH_LAST = CNT_W'(2 * ARR_SIZE - 3);
    localparam logic [CNT_W-1:0] c_STORE_LAST = CNT_W'(STORE_LEN - 1);
    localparam logic [1:0]       c_SIG_HOLD   = 2'b00;
    localparam logic [1:0]       c_SIG_STREAM = 2'b01;
    localparam logic [1:0]       c_SIG_FLUSH  = 2'b10;
    localparam logic [1:0]       c_SIG_DRAIN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COMPUTE = 3'd2,
        S_FLUSH   = 3'd3,
        S_STORE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       k_last_q;
    logic [OP_ADDR_W-1:0]   base_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   acc_reset_q;
    logic [1:0]             sig_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [OP_ADDR_W-1:0]   op_addr_q;
    logic                   mode_en_q;
    logic                   store_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_last_q    <= '0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_reset_q <= 1'b0;
            sig_q       <= c_SIG_HOLD;
            rd_addr_q   <= '0;
            op_addr_q   <= '0;
            mode_en_q   <= 1'b0;
            store_en_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_reset_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (k_len != 8'd0) begin
                            k_last_q    <= CNT_W'(k_len - 8'd1);
                            base_q      <= out_base;
                            state_q     <= S_CLEAR;
                            busy_q      <= 1'b1;
                            acc_reset_q <= 1'b1;
                            rd_addr_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_COMPUTE;
                    sig_q     <= c_SIG_STREAM;
                    mode_en_q <= 1'b1;
                    cnt_q     <= '0;
                end
                S_COMPUTE: begin
                    if (!stall) begin
                        if (cnt_q == k_last_q) begin
                            // rd_addr keeps the last beat address through FLUSH
                            state_q <= S_FLUSH;
                            sig_q   <= c_SIG_FLUSH;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!stall) begin
                        if (cnt_q == c_FLUSH_LAST) begin
                            state_q    <= S_STORE;
                            sig_q      <= c_SIG_DRAIN;
                            mode_en_q  <= 1'b0;
                            store_en_q <= 1'b1;
                            cnt_q      <= '0;
                            op_addr_q  <= base_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_STORE: begin
                    if (!stall) begin
                        if (cnt_q == c_STORE_LAST) begin
                            state_q    <= S_DONE;
                            sig_q      <= c_SIG_HOLD;
                            store_en_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            op_addr_q <= op_addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A stalled beat must not be consumed in the very cycle the stall is raised,
    // so the two strobes are masked by the live stall input.
    assign i_mode       = mode_en_q  & ~stall;
    assign store_output = store_en_q & ~stall;

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign acc_reset    = acc_reset_q;
    assign state_signal = sig_q;
    assign rd_addr      = rd_addr_q;
    assign op_buf_addr  = op_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// tb_systolic_sequencer : randomized self-checking bench with a tile-level model
// Revision: 1.0
// ============================================================================
module tb_systolic_sequencer;

    localparam int ARR_SIZE  = 4;
    localparam int ADDR_W    = 7;
    localparam int OP_ADDR_W = 4;
    localparam int FLUSH_LEN = 2 * ARR_SIZE - 2;
    localparam int STORE_LEN = ARR_SIZE * ARR_SIZE;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [7:0]           k_len;
    logic [OP_ADDR_W-1:0] out_base;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [1:0]           state_signal;
    logic                 i_mode;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 acc_reset;
    logic                 store_output;
    logic [OP_ADDR_W-1:0] op_buf_addr;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_sequencer #(
        .ARR_SIZE  (ARR_SIZE),
        .ADDR_W    (ADDR_W),
        .OP_ADDR_W (OP_ADDR_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .out_base     (out_base),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .state_signal (state_signal),
        .i_mode       (i_mode),
        .rd_addr      (rd_addr),
        .acc_reset    (acc_reset),
        .store_output (store_output),
        .op_buf_addr  (op_buf_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One scheduled cycle of work as seen by the datapath.
    typedef struct packed {
        logic [1:0] sig;
        logic       imode;
        logic       store;
        logic       acc;
        logic       dn;
        logic       stallable;
        int         rd;
        int         op;
        int         idx;
        int         stall_left;
    } item_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {13'd0, busy, done, err, acc_reset, i_mode, store_output,
                state_signal, rd_addr, op_buf_addr};
    endfunction

    function automatic item_t mk(input logic [1:0] sig, input logic im, input logic st,
                                 input logic acc, input logic dn, input logic sb,
                                 input int rd, input int op, input int idx);
        item_t it;
        it.sig        = sig;
        it.imode      = im;
        it.store      = st;
        it.acc        = acc;
        it.dn         = dn;
        it.stallable  = sb;
        it.rd         = rd;
        it.op         = op;
        it.idx        = idx;
        it.stall_left = 0;
        return it;
    endfunction

    // mode: 0 no stall, 1 random stall, 2 scripted stall (beat 2 x3, store idx 5 x2)
    // Entered and left just after a falling edge.
    task automatic run_tile(input int k, input int base, input int mode,
                            input int abort_idx, input bit busy_start);
        item_t q[$];
        item_t it;
        int    total_stalls = 0;
        int    cyc = 0;
        int    done_cyc = -1;
        bit    stall_now;
        bit    exp_im;
        bit    exp_st;
        int    amask = (1 << ADDR_W) - 1;
        int    omask = (1 << OP_ADDR_W) - 1;

        q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0));
        for (int i = 0; i < k; i++)
            q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, i & amask, 0, i));
        for (int i = 0; i < FLUSH_LEN; i++)
            q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (k - 1) & amask, 0, i));
        for (int i = 0; i < STORE_LEN; i++)
            q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, (base + i) & omask, i));
        q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0));

        for (int i = 0; i < q.size(); i++) begin
            if (mode == 1 && q[i].stallable && $urandom_range(0, 7) == 0)
                q[i].stall_left = $urandom_range(1, 3);
            if (mode == 2 && q[i].sig == 2'b01 && q[i].idx == 2)
                q[i].stall_left = 3;
            if (mode == 2 && q[i].sig == 2'b11 && q[i].idx == 5)
                q[i].stall_left = 2;
            total_stalls += q[i].stall_left;
        end

        start    = 1'b1;
        k_len    = 8'(k);
        out_base = OP_ADDR_W'(base);
        stall    = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        k_len    = 8'($urandom);
        out_base = OP_ADDR_W'($urandom);

        while (q.size() > 0) begin
            it = q[0];
            if (it.stallable)
                stall_now = (it.stall_left > 0);
            else
                stall_now = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            stall = stall_now;
            if (busy_start && cyc == 5) begin
                start    = 1'b1;
                k_len    = 8'($urandom_range(1, 255));
                out_base = OP_ADDR_W'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            exp_im = it.imode && !(it.stallable && stall_now);
            exp_st = it.store && !(it.stallable && stall_now);
            chk("ctl", {24'd0, busy, done, err, acc_reset, i_mode, store_output, state_signal},
                {24'd0, 1'b1, it.dn, 1'b0, it.acc, exp_im, exp_st, it.sig});
            if (it.sig == 2'b01 || it.sig == 2'b10)
                chk("rd_addr", {25'd0, rd_addr}, it.rd);
            if (it.sig == 2'b11)
                chk("op_buf_addr", {28'd0, op_buf_addr}, it.op);
            if (done)
                done_cyc = cyc;

            if (it.sig == 2'b11 && it.idx == abort_idx) begin
                rst = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                stall = 1'b0;
                #1;
                chk("rst_abort", all_out(), 32'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    #1;
                    chk("post_rst", all_out(), 32'd0);
                end
                return;
            end

            if (it.stallable && stall_now)
                q[0].stall_left = q[0].stall_left - 1;
            else
                void'(q.pop_front());
            cyc++;
            @(negedge clk);
        end

        start = 1'b0;
        stall = 1'b0;
        #1;
        chk("done_cycle", done_cyc, k + 23 + total_stalls);
        chk("idle_after", {24'd0, busy, done, err, acc_reset, i_mode, store_output, state_signal},
            32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        k_len    = 8'd0;
        out_base = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("reset_vals", all_out(), 32'd0);
        end

        // Zero-length request is rejected with a one-cycle err pulse.
        @(negedge clk);
        start    = 1'b1;
        k_len    = 8'd0;
        out_base = 4'd9;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_pulse", all_out(), 32'h0001_0000);
        @(negedge clk);
        #1;
        chk("err_clear", all_out(), 32'd0);
        @(negedge clk);

        run_tile(8, 0, 0, -1, 1'b0);
        run_tile(4, 3, 2, -1, 1'b0);
        run_tile(5, 12, 0, -1, 1'b1);
        run_tile(3, $urandom_range(0, 15), 0, 7, 1'b0);
        run_tile(1, $urandom_range(0, 15), 0, -1, 1'b0);
        for (int t = 0; t < 6; t++)
            run_tile($urandom_range(1, 40), $urandom_range(0, 15), 1, -1, t[0]);
        run_tile(255, $urandom_range(0, 15), 0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
